// File: rtl/cd40147_pkg.sv
// Shared constants and reference encoding function for the CD40147-style
// 10-to-4 BCD priority encoder.
package cd40147_pkg;

  localparam int          N_IN     = 10;
  localparam int          W_OUT    = 4;
  localparam logic [3:0]  BCD_NONE = 4'd0;

  // Index of the highest asserted line; BCD_NONE when no line is set.
  function automatic logic [3:0] prio_enc10(input logic [9:0] v);
    logic [3:0] r;
    if      (v[9]) r = 4'd9;
    else if (v[8]) r = 4'd8;
    else if (v[7]) r = 4'd7;
    else if (v[6]) r = 4'd6;
    else if (v[5]) r = 4'd5;
    else if (v[4]) r = 4'd4;
    else if (v[3]) r = 4'd3;
    else if (v[2]) r = 4'd2;
    else if (v[1]) r = 4'd1;
    else           r = BCD_NONE;
    return r;
  endfunction

endpackage

// File: rtl/cd40147_prio_core.sv
// Purely combinational 10-line priority encoder core: BCD index of the
// highest set line plus an "any line set" flag.
module cd40147_prio_core
  import cd40147_pkg::*;
(
  input  logic [9:0] i_lines,
  output logic [3:0] o_enc,
  output logic       o_any
);

  // Top-down priority chain; i_lines[9] wins over everything below it.
  always_comb begin
    o_enc = prio_enc10(i_lines);
    o_any = |i_lines;
  end

endmodule

// File: rtl/cd40147_assign_sync.sv
// CD40147-style 10-line to BCD priority encoder, active-high on both sides,
// with an optional single output register stage.
module cd40147_assign_sync
  import cd40147_pkg::*;
#(
  parameter int N_IN    = 10,
  parameter int W_OUT   = 4,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   i,
  output logic [W_OUT-1:0]  o,
  output logic              o_valid
);

  // The encoder is defined only for exactly ten lines and a 4-bit BCD code.
  generate
    if (N_IN != 10 || W_OUT != 4) begin : g_bad_params
      $error("cd40147_assign_sync: N_IN must be 10 and W_OUT must be 4");
    end
  endgenerate

  logic [3:0] w_enc_p0;
  logic       w_any_p0;

  // Stage p0: combinational encode of the current input lines.
  cd40147_prio_core u_core (
    .i_lines (i[9:0]),
    .o_enc   (w_enc_p0),
    .o_any   (w_any_p0)
  );

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [3:0] r_enc_p1;
      logic       r_vld_p1;

      // Stage p1: register the encoding; reset wins over incoming data.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_enc_p1 <= BCD_NONE;
          r_vld_p1 <= 1'b0;
        end else begin
          r_enc_p1 <= w_enc_p0;
          r_vld_p1 <= w_any_p0;
        end
      end

      assign o       = r_enc_p1;
      assign o_valid = r_vld_p1;
    end else begin : g_comb
      assign o       = w_enc_p0;
      assign o_valid = w_any_p0;
    end
  endgenerate

endmodule

// File: tb/tb_cd40147_assign_sync.sv
// Scoreboard bench for cd40147_assign_sync (registered configuration).
module tb_cd40147_assign_sync;

  logic       clk;
  logic       rst;
  logic [9:0] tb_i;
  logic [3:0] o;
  logic       o_valid;

  typedef struct {
    logic [3:0] o;
    logic       v;
    logic [9:0] stim;
    logic       r;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 0;

  cd40147_assign_sync #(.N_IN(10), .W_OUT(4), .OUT_REG(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .i       (tb_i),
    .o       (o),
    .o_valid (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the index of the most significant set bit is floor(log2(v)),
  // i.e. clog2(v+1)-1 for v>0.
  function automatic exp_t model(input logic r, input logic [9:0] v);
    exp_t e;
    e.stim = v;
    e.r    = r;
    if (r || v == 10'd0) begin
      e.o = 4'd0;
      e.v = 1'b0;
    end else begin
      e.o = 4'($clog2(int'(v) + 1) - 1);
      e.v = 1'b1;
    end
    return e;
  endfunction

  // Drive one cycle of stimulus away from the active edge and queue its result.
  task automatic apply(input logic r, input logic [9:0] v);
    @(negedge clk);
    rst  = r;
    tb_i = v;
    exp_q.push_back(model(r, v));
  endtask

  // Monitor: the registered outputs are presented every cycle after an edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (o !== e.o) begin
          n_errors++;
          $display("FAIL enc: rst=%0b i=%b o=%0d expected %0d", e.r, e.stim, o, e.o);
        end
        n_checks++;
        if (o_valid !== e.v) begin
          n_errors++;
          $display("FAIL valid: rst=%0b i=%b o_valid=%0b expected %0b", e.r, e.stim, o_valid, e.v);
        end
        n_checks++;
        if (!(o <= 4'd9)) begin
          n_errors++;
          $display("FAIL range: i=%b o=%0d expected <=9", e.stim, o);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic [9:0] v;
    rst  = 1'b1;
    tb_i = 10'h3FF;

    // Reset held two cycles with all lines high, then released.
    apply(1'b1, 10'h3FF);
    apply(1'b1, 10'h3FF);
    apply(1'b0, 10'h3FF);

    // Walking one.
    for (int k = 0; k < 10; k++) begin
      v = 10'd1 << k;
      apply(1'b0, v);
    end

    // None asserted and priority cases.
    apply(1'b0, 10'b0000000000);
    apply(1'b0, 10'b1100000000);
    apply(1'b0, 10'b0111111111);
    apply(1'b0, 10'b0000000011);
    apply(1'b0, 10'b0000000001);
    apply(1'b0, 10'b0000000000);

    // Exhaustive sweep.
    for (int n = 0; n < 1024; n++) begin
      v = 10'(n);
      apply(1'b0, v);
    end

    // Mid-stream reset for one cycle.
    apply(1'b0, 10'b0000100000);
    apply(1'b1, 10'b0000100000);
    apply(1'b0, 10'b0000100000);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      v = 10'($urandom_range(1023));
      apply(($urandom_range(15) == 0), v);
    end

    apply(1'b0, 10'd0);
    stim_done = 1;
  end

  // Finish once the scoreboard drains, bounded by a cycle budget.
  initial begin
    int cyc;
    wait (stim_done);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL timeout: stimulus_done=%0b expected 1", stim_done);
    $fatal(1, "timeout");
  end

endmodule
